// File: rtl/pattern_matcher_if.sv
// Beat, pattern-load and result signals of pattern_matcher grouped as one bus.
// The match_cnt member exists only when MATCH_CNT_EN is defined.
interface pattern_matcher_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 pat_load;
  logic [WIDTH-1:0]     pat_in;
  logic [WIDTH-1:0]     mask_in;
  logic                 in_valid;
  logic [WIDTH-1:0]     data_in;
  logic [WIDTH-1:0]     xnor_out;
  logic                 out_valid;
  logic                 match;
  logic                 locked;
`ifdef MATCH_CNT_EN
  logic [CNT_WIDTH-1:0] match_cnt;
`endif

  modport master (
    output pat_load, pat_in, mask_in, in_valid, data_in,
    input  xnor_out, out_valid, match, locked
`ifdef MATCH_CNT_EN
    , match_cnt
`endif
  );

  modport slave (
    input  pat_load, pat_in, mask_in, in_valid, data_in,
    output xnor_out, out_valid, match, locked
`ifdef MATCH_CNT_EN
    , match_cnt
`endif
  );
endinterface

// File: rtl/pattern_matcher.sv
// Masked pattern compare with 1-cycle result latency and a SEARCH/TRACK/LOCKED run detector.
// Define MATCH_CNT_EN to add the saturating match_cnt counter.
module pattern_matcher #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pattern_matcher_if.slave  bus
);
  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  if (WIDTH < 1 || LOCK_COUNT < 1 || LOCK_COUNT > 255 || CNT_WIDTH < 2) begin : g_bad_param
    $error("pattern_matcher: parameter out of range");
  end

  state_t           state_reg;
  logic [RUN_W-1:0] run_reg;
  logic [WIDTH-1:0] pattern_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] xnor_reg;
  logic             out_valid_reg;
  logic             match_reg;
  logic             locked_reg;

  logic [WIDTH-1:0] xnor_now;
  logic [WIDTH-1:0] bit_ok;
  logic             match_now;
  logic [RUN_W-1:0] run_inc;
  logic             run_done;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign xnor_now[gi] = ~(bus.data_in[gi] ^ pattern_reg[gi]);
    assign bit_ok[gi]   = xnor_now[gi] | ~mask_reg[gi];
  end

  assign match_now = &bit_ok;
  assign run_inc   = run_reg + RUN_W'(1);
  assign run_done  = (run_inc == RUN_W'(LOCK_COUNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= SEARCH;
      run_reg       <= '0;
      pattern_reg   <= '0;
      mask_reg      <= '0;
      xnor_reg      <= '0;
      out_valid_reg <= 1'b0;
      match_reg     <= 1'b0;
      locked_reg    <= 1'b0;
    end else begin
      out_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        xnor_reg  <= xnor_now;
        match_reg <= match_now;
      end

      if (bus.pat_load) begin
        // The beat in this cycle still reports its result, but the run restarts.
        pattern_reg <= bus.pat_in;
        mask_reg    <= bus.mask_in;
        state_reg   <= SEARCH;
        run_reg     <= '0;
        locked_reg  <= 1'b0;
      end else if (bus.in_valid) begin
        case (state_reg)
          SEARCH, TRACK: begin
            // run is 0 in SEARCH, so run_done there means LOCK_COUNT == 1.
            if (match_now) begin
              run_reg <= run_inc;
              if (run_done) begin
                state_reg  <= LOCKED;
                locked_reg <= 1'b1;
              end else begin
                state_reg  <= TRACK;
              end
            end else begin
              state_reg <= SEARCH;
              run_reg   <= '0;
            end
          end
          LOCKED: begin
            if (!match_now) begin
              state_reg  <= SEARCH;
              run_reg    <= '0;
              locked_reg <= 1'b0;
            end
          end
          default: begin
            state_reg  <= SEARCH;
            run_reg    <= '0;
            locked_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.xnor_out  = xnor_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.match     = match_reg;
  assign bus.locked    = locked_reg;

`ifdef MATCH_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (bus.in_valid && match_now && (cnt_reg != {CNT_WIDTH{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign bus.match_cnt = cnt_reg;
`endif
endmodule

// File: doc/pattern_matcher.md
PATTERN_MATCHER -- requirements
Module: pattern_matcher

Interface
REQ-001 Parameter WIDTH, default 8: data, pattern and mask width in bits (1 or more).
REQ-002 Parameter LOCK_COUNT, default 3: consecutive matching beats required to lock (1 to 255).
REQ-003 Parameter CNT_WIDTH, default 16: match counter width (2 or more).
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 Port pat_load  input  1: loads pat_in and mask_in into the internal pattern and mask registers.
REQ-007 Port pat_in  input  WIDTH: reference pattern.
REQ-008 Port mask_in  input  WIDTH: compare mask; 1 = bit compared, 0 = don't-care.
REQ-009 Port in_valid  input  1: data_in beat is valid this cycle.
REQ-010 Port data_in  input  WIDTH: sample to compare.
REQ-011 Port xnor_out  output  WIDTH: registered bitwise equality ~(data_in ^ pattern) of the last accepted beat.
REQ-012 Port out_valid  output  1: one-cycle pulse; xnor_out and match are valid.
REQ-013 Port match  output  1: registered masked full match of the last accepted beat.
REQ-014 Port locked  output  1: FSM is in LOCKED.
REQ-015 Port match_cnt  output  CNT_WIDTH: saturating count of matching beats; present only with MATCH_CNT_EN.

Function
REQ-016 A beat SHALL be accepted on every rising clk edge with in_valid=1; no backpressure.
REQ-017 Latency SHALL be 1 cycle: an accepted beat drives out_valid=1 with xnor_out and match on the following cycle.
REQ-018 out_valid SHALL be 0 in every cycle after a cycle with in_valid=0; xnor_out and match SHALL hold their last values.
REQ-019 match SHALL be 1 if and only if the AND of (xnor_bit OR NOT mask_bit) over all WIDTH bits is 1.
REQ-020 With mask all zeros, every accepted beat SHALL match.
REQ-021 pat_load SHALL update pattern and mask at the clock edge; a beat accepted in the same cycle SHALL be compared against the old pattern and mask.
REQ-022 The FSM SHALL have three states: SEARCH, TRACK and LOCKED; it SHALL keep an internal run counter of width ceil(log2(LOCK_COUNT+1)).
REQ-023 SEARCH: a matching beat sets run=1 and goes to TRACK, or directly to LOCKED if LOCK_COUNT=1; a mismatching beat stays in SEARCH.
REQ-024 TRACK: a matching beat increments run, and when run reaches LOCK_COUNT goes to LOCKED; a mismatching beat sets run=0 and goes to SEARCH.
REQ-025 LOCKED: a matching beat stays in LOCKED; a mismatching beat sets run=0 and goes to SEARCH.
REQ-026 The FSM SHALL evaluate the current data_in combinationally, so locked rises on the same edge as out_valid of the LOCK_COUNT-th consecutive match.
REQ-027 Cycles with in_valid=0 SHALL NOT change the state or run; gaps do not break a run.
REQ-028 pat_load SHALL force SEARCH with run=0, taking priority over any concurrent beat's FSM effect; that beat's out_valid, xnor_out and match SHALL still be produced.

Reset
REQ-029 rst_n=0 SHALL immediately clear pattern, mask, xnor_out, out_valid, match, locked, run and match_cnt to 0, and set the state to SEARCH, without waiting for a clk edge.
REQ-030 A beat in flight when reset asserts SHALL be discarded; the first out_valid after reset SHALL come from a beat accepted after rst_n is released.

Configuration
REQ-031 Macro MATCH_CNT_EN defined: the match_cnt port exists and increments by 1 on each accepted matching beat, holds at 2^CNT_WIDTH-1, and is unaffected by pat_load.
REQ-032 Macro MATCH_CNT_EN undefined: no match_cnt port and no counter logic; all other behaviour is identical.

Verification (WIDTH=8, LOCK_COUNT=3, CNT_WIDTH=4, MATCH_CNT_EN defined)
REQ-033 Load pattern 0xA5 with mask 0xFF, then send beat 0xA5 -> next cycle out_valid=1, xnor_out=0xFF, match=1; send beat 0x5A -> xnor_out=0x00, match=0.
REQ-034 Mask 0xF0, pattern 0xA5, send beat 0xA3 -> xnor_out=0xF9, match=1.
REQ-035 Three matching beats with idle gaps between them -> locked=1 with the third out_valid; then one mismatch -> locked=0, state SEARCH.
REQ-036 Two matches, then pat_load in the same cycle as a third match -> out_valid=1, match=1, locked stays 0, run=0.
REQ-037 Send 20 matching beats -> match_cnt reaches 15 and holds at 15.
REQ-038 Assert rst_n=0 mid-stream while locked=1 -> all outputs read 0 before the next clk edge; after release, no out_valid until a new beat is sent.
